// File: rtl/ysyx_23060077_idu_pipe_if.sv
// IFU -> IDU -> EXU handshake and decoded-record bundle for ysyx_23060077_idu_pipe.
// Defines YSYX_23060077_ALU_OPT_WIDTH if the core has not already done so.
`ifndef YSYX_23060077_ALU_OPT_WIDTH
`define YSYX_23060077_ALU_OPT_WIDTH 4
`endif

interface ysyx_23060077_idu_pipe_if #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) ();
    logic                                    flush;
    logic                                    in_valid;
    logic                                    in_ready;
    logic [DATA_W-1:0]                       in_pc;
    logic [31:0]                             in_inst;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [DATA_W-1:0]                       out_pc;
    logic [REG_W-1:0]                        rd;
    logic [REG_W-1:0]                        rs1;
    logic [REG_W-1:0]                        rs2;
    logic                                    rd_wen;
    logic [DATA_W-1:0]                       imm;
    logic [`YSYX_23060077_ALU_OPT_WIDTH-1:0] alu_opt;
    logic [1:0]                              src_sel;
    logic [1:0]                              lsu_opt;
    logic [2:0]                              funct3;
    logic                                    is_jal;
    logic                                    is_jalr;
    logic                                    is_branch;
    logic                                    is_sys;
    logic                                    alu_mul;
    logic                                    alu_div;
    logic                                    illegal;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, rd, rs1, rs2, rd_wen, imm, alu_opt,
               src_sel, lsu_opt, funct3, is_jal, is_jalr, is_branch, is_sys,
               alu_mul, alu_div, illegal
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, rd, rs1, rs2, rd_wen, imm, alu_opt,
               src_sel, lsu_opt, funct3, is_jal, is_jalr, is_branch, is_sys,
               alu_mul, alu_div, illegal
    );
endinterface

// File: rtl/ysyx_23060077_idu_pipe.sv
// Pipelined instruction decoder with a DEPTH-entry decoded-record FIFO.
// Define YSYX_23060077_RV32M_EN to decode RV32M; otherwise M-type OP is illegal.
`ifndef YSYX_23060077_ALU_OPT_WIDTH
`define YSYX_23060077_ALU_OPT_WIDTH 4
`endif

module ysyx_23060077_id_opt (
    input  logic [6:0]                              opcode,
    input  logic [2:0]                              funct3,
    input  logic                                    funct7_b5,
    output logic [`YSYX_23060077_ALU_OPT_WIDTH-1:0] alu_opt
);
    // funct7[5] only distinguishes sub/sra for reg ops and srai for immediates
    always_comb begin
        alu_opt = '0;
        if (opcode == 7'b0110011)
            alu_opt = `YSYX_23060077_ALU_OPT_WIDTH'({funct7_b5, funct3});
        else if (opcode == 7'b0010011)
            alu_opt = `YSYX_23060077_ALU_OPT_WIDTH'({funct7_b5 & (funct3 == 3'b101), funct3});
    end
endmodule

module ysyx_23060077_idu_pipe #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    ysyx_23060077_idu_pipe_if.slave io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ALU_W = `YSYX_23060077_ALU_OPT_WIDTH;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic              rd_wen;
        logic [DATA_W-1:0] imm;
        logic [ALU_W-1:0]  alu_opt;
        logic [1:0]        src_sel;
        logic [1:0]        lsu_opt;
        logic [2:0]        funct3;
        logic              is_jal;
        logic              is_jalr;
        logic              is_branch;
        logic              is_sys;
        logic              alu_mul;
        logic              alu_div;
        logic              illegal;
    } rec_t;

    logic [31:0]      inst;
    logic [6:0]       opc;
    logic             is_lui, is_auipc, is_jal, is_jalr, is_br, is_load;
    logic             is_store, is_opimm, is_op, is_fence, is_sys;
    logic             type_u, type_j, type_i, type_b, type_s, type_r, known;
    logic             use_rd, use_rs1, use_rs2;
    logic             rv32e_bad, m_bad, mul_sel, div_sel, bad;
    logic [31:0]      imm32;
    logic [ALU_W-1:0] opt_w;
    rec_t             dec;

    assign inst     = io.in_inst;
    assign opc      = inst[6:0];
    assign is_lui   = (opc == OP_LUI);
    assign is_auipc = (opc == OP_AUIPC);
    assign is_jal   = (opc == OP_JAL);
    assign is_jalr  = (opc == OP_JALR);
    assign is_br    = (opc == OP_BRANCH);
    assign is_load  = (opc == OP_LOAD);
    assign is_store = (opc == OP_STORE);
    assign is_opimm = (opc == OP_IMM);
    assign is_op    = (opc == OP_REG);
    assign is_fence = (opc == OP_FENCE);
    assign is_sys   = (opc == OP_SYS);

    assign type_u  = is_lui | is_auipc;
    assign type_j  = is_jal;
    assign type_i  = is_jalr | is_load | is_opimm | is_sys;
    assign type_b  = is_br;
    assign type_s  = is_store;
    assign type_r  = is_op;
    assign known   = type_u | type_j | type_i | type_b | type_s | type_r | is_fence;
    assign use_rd  = type_u | type_j | type_i | type_r;
    assign use_rs1 = type_i | type_b | type_s | type_r;
    assign use_rs2 = type_b | type_s | type_r;

    // RV32E only has x0..x15, so any used field reaching x16+ cannot be executed
    assign rv32e_bad = (REG_W < 5) &&
                       ((use_rd & inst[11]) | (use_rs1 & inst[19]) | (use_rs2 & inst[24]));

`ifdef YSYX_23060077_RV32M_EN
    assign mul_sel = inst[25] & is_op & ~inst[14];
    assign div_sel = inst[25] & is_op &  inst[14];
    assign m_bad   = 1'b0;
`else
    assign mul_sel = 1'b0;
    assign div_sel = 1'b0;
    assign m_bad   = is_op & (inst[31:25] == 7'b0000001);
`endif

    assign bad = ~known | rv32e_bad | m_bad;

    always_comb begin
        imm32 = '0;
        if (type_u)
            imm32 = {inst[31:12], 12'b0};
        else if (type_j)
            imm32 = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        else if (type_b)
            imm32 = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        else if (type_s)
            imm32 = 32'($signed({inst[31:25], inst[11:7]}));
        else if (is_sys)
            imm32 = 32'($signed(inst[31:15]));
        else if (type_i)
            imm32 = 32'($signed(inst[31:20]));
    end

    ysyx_23060077_id_opt u_id_opt (
        .opcode    (opc),
        .funct3    (inst[14:12]),
        .funct7_b5 (inst[30]),
        .alu_opt   (opt_w)
    );

    // Illegal records still travel down the pipe, but with all side effects squashed
    always_comb begin
        dec           = '0;
        dec.pc        = io.in_pc;
        dec.rd        = use_rd  ? inst[7  +: REG_W] : '0;
        dec.rs1       = use_rs1 ? inst[15 +: REG_W] : '0;
        dec.rs2       = use_rs2 ? inst[20 +: REG_W] : '0;
        dec.rd_wen    = use_rd & ~bad;
        dec.imm       = DATA_W'($signed(imm32));
        dec.alu_opt   = opt_w;
        dec.src_sel   = {is_auipc | is_br, is_auipc | is_br | is_op};
        dec.lsu_opt   = {is_store & ~bad, is_load & ~bad};
        dec.funct3    = inst[14:12];
        dec.is_jal    = is_jal;
        dec.is_jalr   = is_jalr;
        dec.is_branch = is_br;
        dec.is_sys    = is_sys;
        dec.alu_mul   = mul_sel & ~bad;
        dec.alu_div   = div_sel & ~bad;
        dec.illegal   = bad;
    end

    rec_t             mem_q [DEPTH];
    rec_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full, push, pop;
    rec_t             head;

    assign full         = (count_q == (PTR_W+1)'(DEPTH));
    assign io.in_ready  = ~full & ~io.flush;
    assign io.out_valid = (count_q != '0);
    assign push         = io.in_valid & io.in_ready;
    assign pop          = io.out_valid & io.out_ready & ~io.flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (io.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign io.out_pc    = head.pc;
    assign io.rd        = head.rd;
    assign io.rs1       = head.rs1;
    assign io.rs2       = head.rs2;
    assign io.rd_wen    = head.rd_wen;
    assign io.imm       = head.imm;
    assign io.alu_opt   = head.alu_opt;
    assign io.src_sel   = head.src_sel;
    assign io.lsu_opt   = head.lsu_opt;
    assign io.funct3    = head.funct3;
    assign io.is_jal    = head.is_jal;
    assign io.is_jalr   = head.is_jalr;
    assign io.is_branch = head.is_branch;
    assign io.is_sys    = head.is_sys;
    assign io.alu_mul   = head.alu_mul;
    assign io.alu_div   = head.alu_div;
    assign io.illegal   = head.illegal;
endmodule

// File: tb/tb_ysyx_23060077_idu_pipe.sv
// Bench for ysyx_23060077_idu_pipe: an RV32I and an RV32E instance run in lockstep
// against a queue-based reference model.
`ifndef YSYX_23060077_ALU_OPT_WIDTH
`define YSYX_23060077_ALU_OPT_WIDTH 4
`endif

module tb_ysyx_23060077_idu_pipe;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_wen;
        logic [31:0] imm;
        logic [3:0]  alu_opt;
        logic [1:0]  src_sel;
        logic [1:0]  lsu_opt;
        logic [2:0]  funct3;
        logic        is_jal;
        logic        is_jalr;
        logic        is_branch;
        logic        is_sys;
        logic        alu_mul;
        logic        alu_div;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_ready = 1'b0;

    int tests  = 0;
    int failed = 0;
    logic [63:0] model_q[$];

    ysyx_23060077_idu_pipe_if #(.REG_W(5), .DATA_W(32)) bus ();
    ysyx_23060077_idu_pipe_if #(.REG_W(4), .DATA_W(32)) bus_e ();

    assign bus.flush       = flush;
    assign bus.in_valid    = in_valid;
    assign bus.in_pc       = in_pc;
    assign bus.in_inst     = in_inst;
    assign bus.out_ready   = out_ready;
    assign bus_e.flush     = flush;
    assign bus_e.in_valid  = in_valid;
    assign bus_e.in_pc     = in_pc;
    assign bus_e.in_inst   = in_inst;
    assign bus_e.out_ready = out_ready;

    ysyx_23060077_idu_pipe #(.REG_W(5), .DATA_W(32), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    ysyx_23060077_idu_pipe #(.REG_W(4), .DATA_W(32), .DEPTH(DEPTH)) u_dut_e (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus_e)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the ISA tables: classify the format, then derive fields.
    function automatic exp_t refDecode(input logic [31:0] inst, input logic [31:0] pc, input int reg_w);
        exp_t e;
        byte  k;
        logic [4:0] mask;
        logic u_rd, u_rs1, u_rs2, bad, m_type, op, opi;
        e    = '0;
        mask = (reg_w == 4) ? 5'h0F : 5'h1F;
        case (inst[6:0])
            7'b0110111, 7'b0010111:                         k = "U";
            7'b1101111:                                     k = "J";
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: k = "I";
            7'b1100011:                                     k = "B";
            7'b0100011:                                     k = "S";
            7'b0110011:                                     k = "R";
            7'b0001111:                                     k = "F";
            default:                                        k = "X";
        endcase
        u_rd   = (k == "U") || (k == "J") || (k == "I") || (k == "R");
        u_rs1  = (k == "I") || (k == "B") || (k == "S") || (k == "R");
        u_rs2  = (k == "B") || (k == "S") || (k == "R");
        op     = (inst[6:0] == 7'b0110011);
        opi    = (inst[6:0] == 7'b0010011);
        m_type = op && (inst[31:25] == 7'b0000001);
        bad    = (k == "X") ||
                 ((reg_w == 4) && ((u_rd && inst[11]) || (u_rs1 && inst[19]) || (u_rs2 && inst[24])));
`ifndef YSYX_23060077_RV32M_EN
        bad = bad || m_type;
`endif
        e.pc      = pc;
        e.rd      = u_rd  ? (inst[11:7]  & mask) : 5'd0;
        e.rs1     = u_rs1 ? (inst[19:15] & mask) : 5'd0;
        e.rs2     = u_rs2 ? (inst[24:20] & mask) : 5'd0;
        e.rd_wen  = u_rd && !bad;
        e.funct3  = inst[14:12];
        e.illegal = bad;
        if (k == "U")
            e.imm = inst & 32'hFFFF_F000;
        else if (k == "J")
            e.imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        else if (k == "B")
            e.imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        else if (k == "S")
            e.imm = 32'($signed({inst[31:25], inst[11:7]}));
        else if (inst[6:0] == 7'b1110011)
            e.imm = 32'($signed(inst) >>> 15);
        else if (k == "I")
            e.imm = 32'($signed(inst) >>> 20);
        if (op)
            e.alu_opt = {inst[30], inst[14:12]};
        else if (opi)
            e.alu_opt = {inst[30] && (inst[14:12] == 3'd5), inst[14:12]};
        e.src_sel[1] = (inst[6:0] == 7'b0010111) || (inst[6:0] == 7'b1100011);
        e.src_sel[0] = e.src_sel[1] || op;
        e.lsu_opt    = {(k == "S") && !bad, (inst[6:0] == 7'b0000011) && !bad};
        e.is_jal     = (k == "J");
        e.is_jalr    = (inst[6:0] == 7'b1100111);
        e.is_branch  = (k == "B");
        e.is_sys     = (inst[6:0] == 7'b1110011);
`ifdef YSYX_23060077_RV32M_EN
        e.alu_mul = op && inst[25] && !inst[14] && !bad;
        e.alu_div = op && inst[25] &&  inst[14] && !bad;
`endif
        return e;
    endfunction

    function automatic logic [31:0] randInst();
        logic [6:0]  ops [11];
        logic [31:0] r;
        int          sel;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
        r   = $urandom;
        sel = $urandom_range(0, 13);
        if (sel < 11)
            r[6:0] = ops[sel];
        else if (sel == 11) begin
            r[31:25] = 7'b0000001;
            r[6:0]   = 7'b0110011;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRecord(input string pfx, input exp_t obs, input exp_t exp);
        checkOutput({pfx, ".pc"},        obs.pc,                exp.pc);
        checkOutput({pfx, ".rd"},        32'(obs.rd),           32'(exp.rd));
        checkOutput({pfx, ".rs1"},       32'(obs.rs1),          32'(exp.rs1));
        checkOutput({pfx, ".rs2"},       32'(obs.rs2),          32'(exp.rs2));
        checkOutput({pfx, ".rd_wen"},    32'(obs.rd_wen),       32'(exp.rd_wen));
        checkOutput({pfx, ".imm"},       obs.imm,               exp.imm);
        checkOutput({pfx, ".alu_opt"},   32'(obs.alu_opt),      32'(exp.alu_opt));
        checkOutput({pfx, ".src_sel"},   32'(obs.src_sel),      32'(exp.src_sel));
        checkOutput({pfx, ".lsu_opt"},   32'(obs.lsu_opt),      32'(exp.lsu_opt));
        checkOutput({pfx, ".funct3"},    32'(obs.funct3),       32'(exp.funct3));
        checkOutput({pfx, ".class"},     32'({obs.is_jal, obs.is_jalr, obs.is_branch, obs.is_sys}),
                                         32'({exp.is_jal, exp.is_jalr, exp.is_branch, exp.is_sys}));
        checkOutput({pfx, ".mul_div"},   32'({obs.alu_mul, obs.alu_div}), 32'({exp.alu_mul, exp.alu_div}));
        checkOutput({pfx, ".illegal"},   32'(obs.illegal),      32'(exp.illegal));
    endtask

    task automatic checkHead(input logic require_zero);
        exp_t o, oe, e, ee;
        o  = '{pc: bus.out_pc, rd: bus.rd, rs1: bus.rs1, rs2: bus.rs2, rd_wen: bus.rd_wen,
               imm: bus.imm, alu_opt: 4'(bus.alu_opt), src_sel: bus.src_sel, lsu_opt: bus.lsu_opt,
               funct3: bus.funct3, is_jal: bus.is_jal, is_jalr: bus.is_jalr, is_branch: bus.is_branch,
               is_sys: bus.is_sys, alu_mul: bus.alu_mul, alu_div: bus.alu_div, illegal: bus.illegal};
        oe = '{pc: bus_e.out_pc, rd: {1'b0, bus_e.rd}, rs1: {1'b0, bus_e.rs1}, rs2: {1'b0, bus_e.rs2},
               rd_wen: bus_e.rd_wen, imm: bus_e.imm, alu_opt: 4'(bus_e.alu_opt), src_sel: bus_e.src_sel,
               lsu_opt: bus_e.lsu_opt, funct3: bus_e.funct3, is_jal: bus_e.is_jal, is_jalr: bus_e.is_jalr,
               is_branch: bus_e.is_branch, is_sys: bus_e.is_sys, alu_mul: bus_e.alu_mul,
               alu_div: bus_e.alu_div, illegal: bus_e.illegal};
        if (require_zero) begin
            checkRecord("rv32i_rst", o,  '0);
            checkRecord("rv32e_rst", oe, '0);
        end else if (model_q.size() != 0) begin
            e  = refDecode(model_q[0][31:0], model_q[0][63:32], 5);
            ee = refDecode(model_q[0][31:0], model_q[0][63:32], 4);
            checkRecord("rv32i", o,  e);
            checkRecord("rv32e", oe, ee);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model at posedge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic ordy, input logic fl);
        int sz;
        @(negedge clk);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
        sz = model_q.size();
        checkOutput("in_ready",    32'(bus.in_ready),    32'((sz < DEPTH) && !fl));
        checkOutput("out_valid",   32'(bus.out_valid),   32'(sz != 0));
        checkOutput("in_ready_e",  32'(bus_e.in_ready),  32'((sz < DEPTH) && !fl));
        checkOutput("out_valid_e", 32'(bus_e.out_valid), 32'(sz != 0));
        checkHead(1'b0);
        @(posedge clk);
        #1;
        if (fl)
            model_q.delete();
        else begin
            if (sz != 0 && ordy)
                void'(model_q.pop_front());
            if (v && sz < DEPTH)
                model_q.push_back({pc, inst});
        end
    endtask

    initial begin
        logic m_en;
`ifdef YSYX_23060077_RV32M_EN
        m_en = 1'b1;
`else
        m_en = 1'b0;
`endif
        #3;
        checkOutput("rst_out_valid", 32'(bus.out_valid),   32'd0);
        checkOutput("rst_in_ready",  32'(bus.in_ready),    32'd1);
        checkOutput("rst_out_valid_e", 32'(bus_e.out_valid), 32'd0);
        checkHead(1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 32'h8000_0000, 32'h0050_0093, 0, 0);
        checkOutput("addi_latency", 32'(bus.out_valid), 32'd1);
        checkOutput("addi_rd",      32'(bus.rd),        32'd1);
        checkOutput("addi_imm",     bus.imm,            32'd5);
        checkOutput("addi_src_sel", 32'(bus.src_sel),   32'd0);

        applyStimulus(1, 32'h8000_0004, 32'hFE20_8EE3, 0, 0);
        checkOutput("bp_full", 32'(bus.in_ready), 32'd0);
        applyStimulus(1, 32'h8000_0008, 32'h0220_81B3, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        checkOutput("beq_pc",     bus.out_pc,           32'h8000_0004);
        checkOutput("beq_imm",    bus.imm,              32'hFFFF_FFFC);
        checkOutput("beq_branch", 32'(bus.is_branch),   32'd1);
        checkOutput("beq_src",    32'(bus.src_sel),     32'd3);
        checkOutput("beq_rs",     32'({bus.rs1, bus.rs2}), 32'({5'd1, 5'd2}));

        applyStimulus(1, 32'h8000_0008, 32'h0220_81B3, 1, 0);
        checkOutput("mul_illegal", 32'(bus.illegal), 32'(!m_en));
        checkOutput("mul_sel",     32'(bus.alu_mul), 32'(m_en));
        checkOutput("mul_rd",      32'(bus.rd),      32'd3);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);

        applyStimulus(1, 32'h8000_0100, 32'h0050_0093, 0, 0);
        applyStimulus(1, 32'h8000_0104, 32'hFE20_8EE3, 0, 0);
        applyStimulus(1, 32'h8000_0108, 32'h0050_0093, 0, 1);
        checkOutput("flush_empty", 32'(bus.out_valid), 32'd0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);

        applyStimulus(1, 32'h8000_0200, 32'h0020_8833, 0, 0);
        checkOutput("rv32e_x16",   32'(bus_e.illegal), 32'd1);
        checkOutput("rv32i_x16",   32'(bus.illegal),   32'd0);
        applyStimulus(1, 32'h8000_0204, 32'hFFFF_FFFF, 1, 0);
        checkOutput("all_ones",    32'(bus.illegal),   32'd1);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);

        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, $urandom, randInst(),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);

        applyStimulus(1, 32'h8000_0300, randInst(), 0, 0);
        applyStimulus(1, 32'h8000_0304, randInst(), 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_q.delete();
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        checkHead(1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1, 32'h8000_0400, 32'h0050_0093, 0, 0);
        checkOutput("post_rst_accept", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 40; i++)
            applyStimulus($urandom_range(0, 1) != 0, $urandom, randInst(),
                          $urandom_range(0, 1) != 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ysyx_23060077_idu_pipe.md
# ysyx_23060077_idu_pipe

Pipelined, parametrised instruction-decode stage for the ysyx_23060077 core. It sits between IFU and EXU. It accepts `{pc, inst}` over a valid/ready handshake and decodes the instruction fully, deriving the jal/jalr/branch/sys classes from the opcode itself. Decoded records are buffered in a DEPTH-entry FIFO so IFU is decoupled from EXU stalls. Relative to the combinational decoder, it adds flush, RV32E register-width support, illegal-instruction flagging and optional RV32M decode.

## Interface
- `REG_W`, 5: register index width; 4 selects RV32E.
- `DATA_W`, 32: instruction/immediate/pc width.
- `DEPTH`, 2: decoded-record FIFO entries; power of two, ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: reset; the clock is single, reset is asynchronous active-low.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1 / `in_ready` out 1: IFU handshake.
- `in_pc` in DATA_W, `in_inst` in 32: fetched pc and instruction.
- `out_valid` out 1 / `out_ready` in 1: EXU handshake.
- `out_pc` out DATA_W: pc of the head record.
- `rd`, `rs1`, `rs2` out REG_W: register indices; each is 0 when unused.
- `rd_wen` out 1: destination write enable.
- `imm` out DATA_W: decoded immediate.
- `alu_opt` out `YSYX_23060077_ALU_OPT_WIDTH`: produced by an internal `ysyx_23060077_id_opt` instance.
- `src_sel` out 2: bit 1 = AUIPC|BRANCH; bit 0 = AUIPC|BRANCH|OP.
- `lsu_opt` out 2: `{store, load}`.
- `funct3` out 3: `inst[14:12]`.
- `is_jal`, `is_jalr`, `is_branch`, `is_sys` out 1: class flags.
- `alu_mul`, `alu_div` out 1: M-extension selects.
- `illegal` out 1: undecodable instruction.

## Operation
- Opcode classes:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011.
  - LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, FENCE 0001111, SYS 1110011.
  - Any other opcode is illegal.
- Register usage:
  - rs1 is used by I (JALR, LOAD, OP_IMM, SYS), B, S and R types.
  - rs2 is used by B, S and R types.
  - rd_wen is set for U, J, I and R types.
- Immediates (all sign-extended to DATA_W):
  - I: `inst[31:20]`.
  - U: `{inst[31:12], 12'b0}`.
  - J: `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
  - B: `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - S: `{inst[31:25], inst[11:7]}`.
  - SYS: `inst[31:15]` (carries csr and zimm).
  - Otherwise 0.
- Illegal conditions:
  - Unknown opcode.
  - REG_W=4 and any used register field has bit 4 set.
  - M-type OP (`inst[31:25]`=0000001) when RV32M is compiled out.
- An illegal record is still enqueued with `illegal`=1, and `rd_wen`, `lsu_opt`, `alu_mul`, `alu_div` forced to 0.
- Decode is combinational on `in_inst`. The result is written into the FIFO tail on push; outputs read the FIFO head.
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready & !flush`.
- `in_ready` = `!full & !flush`. `out_valid` = `count != 0`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, pushes are blocked even if a pop occurs that cycle (no full bypass).
- `flush` clears pointers and count on the next edge and discards every record, including any offered input that cycle.

## Timing
- Latency: a record pushed at edge N is visible with `out_valid`=1 from edge N onward (the next cycle). There is no same-cycle bypass.
- Throughput: 1 record per cycle while not full and `out_ready`=1.
- Output payload is stable while `out_valid & !out_ready`.
- Reset (`rst_n`=0, asynchronous): pointers, count and all storage are cleared. Result: `out_valid`=0, `in_ready`=1, and every decoded output reads 0.
- Reset asserted mid-stream drops all records. The first accept after reset is allowed on the first edge with `rst_n`=1.

## Configuration
- `YSYX_23060077_RV32M_EN` defined: `alu_mul` = `inst[25]` & OP & !`funct3[2]`; `alu_div` = `inst[25]` & OP & `funct3[2]`.
- Undefined: `alu_mul` and `alu_div` are tied to 0, and M-type OP instructions are flagged illegal.

## Test plan
- addi x1,x0,5 (0x00500093) -> rd=1, rd_wen=1, rs1=0, rs2=0, imm=5, src_sel=00, lsu_opt=00, out_valid one cycle after accept.
- beq x1,x2,-4 (0xFE208EE3) -> is_branch=1, rs1=1, rs2=2, rd_wen=0, rd=0, imm=0xFFFFFFFC, src_sel=11.
- mul x3,x1,x2 (0x022081B3):
  - With macro -> alu_mul=1, illegal=0, rd=3.
  - Without macro -> illegal=1, rd_wen=0.
- DEPTH=2 backpressure with out_ready=0 -> two accepts, then in_ready=0. Raising out_ready drains both records in push order with correct out_pc.
- flush with 2 records queued and in_valid=1 -> next cycle out_valid=0, count=0, offered instruction dropped.
- REG_W=4, add x16,x1,x2 (0x00208833) -> illegal=1. Also, 0xFFFFFFFF -> illegal=1.
